// File: rtl/spi_ip_shift_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ip_shift_engine_pkg
// Description : Shared state encoding and width helper for the SPI master
//               shift engine and its clock divider.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ip_shift_engine_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LEAD     = 3'd1,
        ST_TRANSFER = 3'd2,
        ST_TRAIL    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Ceiling log2, used to size counters from a maximum count
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : spi_ip_shift_engine_pkg
`default_nettype wire

// File: rtl/spi_ip_shift_engine_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ip_shift_engine_shift_reg
// Description : Parallel-load bidirectional shift register with serial in and
//               serial out. Used once for transmit and once for receive.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ip_shift_engine_shift_reg
    import spi_ip_shift_engine_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             lsb_first,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [WIDTH-1:0] data
);

    logic [WIDTH-1:0] r_data;

    // Load has priority over shift; the head bit leaves first, new bit enters at the tail
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= load_data;
        end else if (shift_en) begin
            if (lsb_first) begin
                r_data <= {serial_in, r_data[WIDTH-1:1]};
            end else begin
                r_data <= {r_data[WIDTH-2:0], serial_in};
            end
        end
    end

    assign serial_out = lsb_first ? r_data[0] : r_data[WIDTH-1];
    assign data       = r_data;

endmodule : spi_ip_shift_engine_shift_reg
`default_nettype wire

// File: rtl/spi_ip_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_ip_shift_engine
// Description : SPI master serializer. Drives the clock divider enable, turns
//               its half-period pulses into SCLK edges for CPOL/CPHA modes
//               0-3, shifts one word out on MOSI, captures MISO and manages
//               SS_n with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ip_shift_engine
    import spi_ip_shift_engine_pkg::*;
#(
    parameter int PARAM_DATA_WIDTH = 8
) (
    input  logic                        sft_clk_i,
    input  logic                        sft_rst_n_i,
    input  logic                        sft_start_i,
    input  logic [PARAM_DATA_WIDTH-1:0] sft_data_i,
    input  logic                        sft_cpol_i,
    input  logic                        sft_cpha_i,
    input  logic                        sft_lsb_first_i,
    input  logic                        sft_time_base_i,
    output logic                        sft_clkd_enable_o,
    output logic                        sft_sclk_o,
    output logic                        sft_mosi_o,
    input  logic                        sft_miso_i,
    output logic                        sft_ss_n_o,
    output logic [PARAM_DATA_WIDTH-1:0] sft_data_o,
    output logic                        sft_busy_o,
    output logic                        sft_done_o
);

    localparam int                  CNT_W     = clogb2(2 * PARAM_DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0]    LAST_EDGE = CNT_W'(2 * PARAM_DATA_WIDTH);

    state_t                      r_state;
    logic                        r_cpol;
    logic                        r_cpha;
    logic                        r_lsb_first;
    logic [CNT_W-1:0]            r_edge_cnt;
    logic                        r_sclk;
    logic                        r_mosi;
    logic                        r_ss_n;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_clkd_enable;
    logic [PARAM_DATA_WIDTH-1:0] r_data_out;

    logic                        w_accept;
    logic                        w_step;
    logic [CNT_W-1:0]            w_next_edge;
    logic                        w_leading;
    logic                        w_tx_pop;
    logic                        w_rx_shift;
    logic                        w_first_bit;
    logic [PARAM_DATA_WIDTH-1:0] w_tx_load_data;
    logic                        w_tx_bit;
    logic [PARAM_DATA_WIDTH-1:0] w_tx_unused_word;
    logic                        w_rx_unused_bit;
    logic [PARAM_DATA_WIDTH-1:0] w_rx_word;

    assign w_accept    = (r_state == ST_IDLE) && sft_start_i;
    assign w_step      = (r_state == ST_TRANSFER) && sft_time_base_i;
    assign w_next_edge = r_edge_cnt + CNT_W'(1);
    assign w_leading   = w_next_edge[0];

    // CPHA=0 puts the first bit on MOSI at start, so the shifter is preloaded
    // one position ahead and only W-1 further bits are popped on trailing edges.
    assign w_first_bit    = sft_lsb_first_i ? sft_data_i[0] : sft_data_i[PARAM_DATA_WIDTH-1];
    assign w_tx_load_data = sft_cpha_i      ? sft_data_i
                          : sft_lsb_first_i ? (sft_data_i >> 1)
                          :                   (sft_data_i << 1);

    assign w_tx_pop   = w_step && (r_cpha ? w_leading
                                          : (!w_leading && (w_next_edge != LAST_EDGE)));
    assign w_rx_shift = w_step && (r_cpha ? !w_leading : w_leading);

    spi_ip_shift_engine_shift_reg #(
        .WIDTH (PARAM_DATA_WIDTH)
    ) u_tx_shift (
        .clk        (sft_clk_i),
        .rst_n      (sft_rst_n_i),
        .load       (w_accept),
        .load_data  (w_tx_load_data),
        .shift_en   (w_tx_pop),
        .lsb_first  (r_lsb_first),
        .serial_in  (1'b0),
        .serial_out (w_tx_bit),
        .data       (w_tx_unused_word)
    );

    spi_ip_shift_engine_shift_reg #(
        .WIDTH (PARAM_DATA_WIDTH)
    ) u_rx_shift (
        .clk        (sft_clk_i),
        .rst_n      (sft_rst_n_i),
        .load       (w_accept),
        .load_data  ({PARAM_DATA_WIDTH{1'b0}}),
        .shift_en   (w_rx_shift),
        .lsb_first  (r_lsb_first),
        .serial_in  (sft_miso_i),
        .serial_out (w_rx_unused_bit),
        .data       (w_rx_word)
    );

    // Frame sequencer with edge counter; every output is registered here
    always_ff @(posedge sft_clk_i) begin
        if (!sft_rst_n_i) begin
            r_state       <= ST_IDLE;
            r_cpol        <= 1'b0;
            r_cpha        <= 1'b0;
            r_lsb_first   <= 1'b0;
            r_edge_cnt    <= '0;
            r_sclk        <= 1'b0;
            r_mosi        <= 1'b0;
            r_ss_n        <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_clkd_enable <= 1'b0;
            r_data_out    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sft_start_i) begin
                        r_cpol        <= sft_cpol_i;
                        r_cpha        <= sft_cpha_i;
                        r_lsb_first   <= sft_lsb_first_i;
                        r_edge_cnt    <= '0;
                        r_sclk        <= sft_cpol_i;
                        r_mosi        <= sft_cpha_i ? 1'b0 : w_first_bit;
                        r_ss_n        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_clkd_enable <= 1'b1;
                        r_state       <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (sft_time_base_i) begin
                        r_state <= ST_TRANSFER;
                    end
                end
                ST_TRANSFER: begin
                    if (sft_time_base_i) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= w_next_edge;
                        if (w_tx_pop) begin
                            r_mosi <= w_tx_bit;
                        end
                        if (w_next_edge == LAST_EDGE) begin
                            r_state <= ST_TRAIL;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (sft_time_base_i) begin
                        r_done        <= 1'b1;
                        r_data_out    <= w_rx_word;
                        r_ss_n        <= 1'b1;
                        r_clkd_enable <= 1'b0;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_mosi  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign sft_clkd_enable_o = r_clkd_enable;
    assign sft_sclk_o        = r_sclk;
    assign sft_mosi_o        = r_mosi;
    assign sft_ss_n_o        = r_ss_n;
    assign sft_data_o        = r_data_out;
    assign sft_busy_o        = r_busy;
    assign sft_done_o        = r_done;

endmodule : spi_ip_shift_engine
`default_nettype wire

// File: tb/tb_spi_ip_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_ip_shift_engine
// Description : Directed self-checking bench for the SPI master shift engine,
//               with a behavioural clock divider and a simple SPI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ip_shift_engine;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] data_in;
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic       time_base;
    logic       clkd_en;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ss_n;
    logic [7:0] data_out;
    logic       busy;
    logic       done;

    logic       loopback;
    logic       slave_miso;
    int         half;
    int         div_cnt;

    int         checks;
    int         passes;
    int         fails;

    int         done_cnt;
    int         done_cyc [2];
    logic [7:0] done_data [2];
    int         ss_first, ss_last, en_first, en_last;
    int         rises, leads;
    int         rise_cyc [2];
    logic [7:0] cap;
    logic       sclk_c1;

    spi_ip_shift_engine #(
        .PARAM_DATA_WIDTH (8)
    ) dut (
        .sft_clk_i         (clk),
        .sft_rst_n_i       (rst_n),
        .sft_start_i       (start),
        .sft_data_i        (data_in),
        .sft_cpol_i        (cpol),
        .sft_cpha_i        (cpha),
        .sft_lsb_first_i   (lsb_first),
        .sft_time_base_i   (time_base),
        .sft_clkd_enable_o (clkd_en),
        .sft_sclk_o        (sclk),
        .sft_mosi_o        (mosi),
        .sft_miso_i        (miso),
        .sft_ss_n_o        (ss_n),
        .sft_data_o        (data_out),
        .sft_busy_o        (busy),
        .sft_done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: counter cleared while disabled, pulse every 'half' cycles
    always @(posedge clk) begin
        if (!clkd_en || !rst_n) div_cnt <= 0;
        else if (div_cnt == half - 1) div_cnt <= 0;
        else div_cnt <= div_cnt + 1;
    end
    assign time_base = (div_cnt == half - 1);
    assign miso      = loopback ? mosi : slave_miso;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a frame request and step to the first cycle after acceptance
    task automatic start_frame(input logic [7:0] d, input logic pol, input logic pha,
                               input logic lsb, input logic hold);
        data_in   = d;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        start     = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    // Observe cycles 1..ncyc of a frame, collecting timing and serial data
    task automatic observe(input int ncyc, input logic pol, input logic lsb,
                           input logic [7:0] sw, input int mid_cyc);
        logic prev;
        int   k;
        done_cnt = 0; ss_first = 0; ss_last = 0; en_first = 0; en_last = 0;
        rises = 0; leads = 0; cap = 8'h00;
        done_cyc[0] = 0; done_cyc[1] = 0; rise_cyc[0] = 0; rise_cyc[1] = 0;
        done_data[0] = 8'h00; done_data[1] = 8'h00;
        prev    = pol;
        sclk_c1 = sclk;
        for (int n = 1; n <= ncyc; n++) begin
            if (done) begin
                if (done_cnt < 2) begin
                    done_cyc[done_cnt]  = n;
                    done_data[done_cnt] = data_out;
                end
                done_cnt++;
            end
            if (!ss_n) begin
                if (ss_first == 0) ss_first = n;
                ss_last = n;
            end
            if (clkd_en) begin
                if (en_first == 0) en_first = n;
                en_last = n;
            end
            if (sclk !== prev) begin
                if (sclk !== pol) begin
                    k = leads % 8;
                    if (lsb) begin
                        cap[k]     = mosi;
                        slave_miso = sw[k];
                    end else begin
                        cap[7-k]   = mosi;
                        slave_miso = sw[7-k];
                    end
                    leads++;
                end
                if (sclk === 1'b1) begin
                    if (rises < 2) rise_cyc[rises] = n;
                    rises++;
                end
            end
            prev = sclk;
            if (mid_cyc != 0 && n == mid_cyc) begin
                start     = 1'b0;
                data_in   = ~data_in;
                cpol      = ~cpol;
                cpha      = ~cpha;
                lsb_first = ~lsb_first;
            end
            if (mid_cyc != 0 && n == mid_cyc + 1) start = 1'b1;
            if (n < ncyc) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        checks = 0; passes = 0; fails = 0;
        rst_n = 1'b0; start = 1'b0; data_in = 8'h00; cpol = 1'b0; cpha = 1'b0;
        lsb_first = 1'b0; loopback = 1'b1; slave_miso = 1'b0; half = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n",  32'(ss_n),     1);
        check("rst_sclk",  32'(sclk),     0);
        check("rst_mosi",  32'(mosi),     0);
        check("rst_busy",  32'(busy),     0);
        check("rst_done",  32'(done),     0);
        check("rst_en",    32'(clkd_en),  0);
        check("rst_data",  32'(data_out), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Mode 0, MSB first, 0xA5 looped back, H=1
        start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        observe(20, 1'b0, 1'b0, 8'h00, 0);
        check("m0_done_cyc",  done_cyc[0], 19);
        check("m0_done_cnt",  done_cnt,    1);
        check("m0_data",      32'(done_data[0]), 32'hA5);
        check("m0_rises",     rises,       8);
        check("m0_ss_first",  ss_first,    1);
        check("m0_ss_last",   ss_last,     18);
        check("m0_mosi",      32'(cap),    32'hA5);
        check("m0_idle_busy", 32'(busy),   0);

        // Mode 3, LSB first, 0x0F out, slave returns 0x3C
        loopback = 1'b0;
        start_frame(8'h0F, 1'b1, 1'b1, 1'b1, 1'b0);
        observe(20, 1'b1, 1'b1, 8'h3C, 0);
        check("m3_sclk_lead", 32'(sclk_c1), 1);
        check("m3_mosi",      32'(cap),     32'h0F);
        check("m3_leads",     leads,        8);
        check("m3_done_cyc",  done_cyc[0],  19);
        check("m3_data",      32'(done_data[0]), 32'h3C);
        check("m3_idle_sclk", 32'(sclk),    1);
        check("m3_idle_mosi", 32'(mosi),    0);
        check("m3_hold_data", 32'(data_out), 32'h3C);

        // Mode 1, 0x81, divider at H=2
        loopback = 1'b1; half = 2;
        start_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        observe(40, 1'b0, 1'b0, 8'h00, 0);
        check("h2_done_cyc", done_cyc[0], 37);
        check("h2_done_cnt", done_cnt,    1);
        check("h2_en_first", en_first,    1);
        check("h2_en_last",  en_last,     36);
        check("h2_period",   rise_cyc[1] - rise_cyc[0], 4);
        check("h2_rises",    rises,       8);
        check("h2_data",     32'(done_data[0]), 32'h81);

        // Start held during busy, re-pulsed and inputs changed at SCLK edge 5
        half = 1;
        start_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        observe(19, 1'b0, 1'b0, 8'h00, 7);
        check("hold_done_cnt", done_cnt,    1);
        check("hold_done_cyc", done_cyc[0], 19);
        check("hold_data",     32'(done_data[0]), 32'h5A);
        @(posedge clk); #1;
        check("hold_idle_busy", 32'(busy), 0);
        check("hold_idle_sclk", 32'(sclk), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("next_busy", 32'(busy), 1);
        check("next_ss_n", 32'(ss_n), 0);
        check("next_sclk", 32'(sclk), 1);

        // Reset asserted at SCLK edge 7 of that frame
        repeat (7) begin
            @(posedge clk); #1;
        end
        check("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_ss_n", 32'(ss_n),     1);
        check("abort_sclk", 32'(sclk),     0);
        check("abort_busy", 32'(busy),     0);
        check("abort_en",   32'(clkd_en),  0);
        check("abort_data", 32'(data_out), 0);
        check("abort_done", 32'(done),     0);
        observe(20, 1'b0, 1'b0, 8'h00, 0);
        check("abort_no_done", done_cnt, 0);

        // Back-to-back frames in mode 2 with start held high
        start_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
        data_in = 8'h34;
        observe(40, 1'b1, 1'b0, 8'h00, 0);
        start = 1'b0;
        check("b2b_done_cnt", done_cnt,    2);
        check("b2b_cyc0",     done_cyc[0], 19);
        check("b2b_gap",      done_cyc[1] - done_cyc[0], 20);
        check("b2b_data0",    32'(done_data[0]), 32'h12);
        check("b2b_data1",    32'(done_data[1]), 32'h34);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_spi_ip_shift_engine
`default_nettype wire
